// File: rtl/pc_unit_if.sv
// Bundles the ID-stage branch inputs and the PC-unit outputs.
// The slave modport is the pc_unit view. The master modport is the core or bench view.
interface pc_unit_if #(
    parameter int ADDR_W = 16,
    parameter int IMM_W  = 9,
    parameter int CNT_W  = 16
);
    logic              stall_i;
    logic              id_valid_i;
    logic              id_branch_i;
    logic [1:0]        id_br_type_i;
    logic [2:0]        id_cond_i;
    logic [IMM_W-1:0]  id_imm_i;
    logic [ADDR_W-1:0] id_pc_i;
    logic [ADDR_W-1:0] reg_val_i;
    logic [2:0]        flags_i;

    logic [ADDR_W-1:0] pc_o;
    logic              fetch_en_o;
    logic              flush_o;
    logic [ADDR_W-1:0] link_o;
    logic              halted_o;
    logic [CNT_W-1:0]  br_count_o;
    logic [CNT_W-1:0]  taken_count_o;

    modport master (
        output stall_i, id_valid_i, id_branch_i, id_br_type_i, id_cond_i,
               id_imm_i, id_pc_i, reg_val_i, flags_i,
        input  pc_o, fetch_en_o, flush_o, link_o, halted_o,
               br_count_o, taken_count_o
    );

    modport slave (
        input  stall_i, id_valid_i, id_branch_i, id_br_type_i, id_cond_i,
               id_imm_i, id_pc_i, reg_val_i, flags_i,
        output pc_o, fetch_en_o, flush_o, link_o, halted_o,
               br_count_o, taken_count_o
    );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit for the pipelined 16-bit core.
// It owns the fetch PC and resolves decode-stage B/BR/PCS/HLT against the {N,V,Z} flags.
// It drives the IF/ID flush, sequences the halt drain, and keeps saturating branch statistics.
module pc_unit #(
    parameter int                ADDR_W       = 16,
    parameter int                IMM_W        = 9,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0,
    parameter int                DRAIN_CYCLES = 3,
    parameter int                CNT_W        = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    pc_unit_if.slave     bus
);
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [1:0] BT_B   = 2'd0;
    localparam logic [1:0] BT_BR  = 2'd1;
    localparam logic [1:0] BT_HLT = 2'd3;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [DW-1:0]     drain_q;
    logic [CNT_W-1:0]  br_cnt_q;
    logic [CNT_W-1:0]  taken_cnt_q;

    logic              act;
    logic              is_bbr;
    logic              is_hlt;
    logic              cond_ok;
    logic              taken;
    logic [ADDR_W-1:0] target;

    // Evaluates a condition code against the flags {N,V,Z}.
    function automatic logic cond_eval(input logic [2:0] cond, input logic [2:0] flags);
        logic n, v, z;
        n = flags[2];
        v = flags[1];
        z = flags[0];
        case (cond)
            3'd0:    return ~z;
            3'd1:    return z;
            3'd2:    return ~z & ~n;
            3'd3:    return n;
            3'd4:    return z | (~z & ~n);
            3'd5:    return n | z;
            3'd6:    return v;
            default: return 1'b1;
        endcase
    endfunction

    // Only a valid branch-class instruction in RUN can act on the PC.
    // Branch inputs are ignored during DRAIN and HALTED.
    assign act     = bus.id_valid_i & bus.id_branch_i & (state_q == RUN);
    assign is_bbr  = (bus.id_br_type_i == BT_B) | (bus.id_br_type_i == BT_BR);
    assign is_hlt  = act & (bus.id_br_type_i == BT_HLT);
    assign cond_ok = cond_eval(bus.id_cond_i, bus.flags_i);
    assign taken   = act & is_bbr & cond_ok;

    // Redirect target: a PC-relative word offset for B, or the register operand for BR.
    always_comb begin
        // NOTE: default assignment first so every path drives target and no latch is inferred.
        target = bus.reg_val_i;
        if (bus.id_br_type_i == BT_B) begin
            target = bus.id_pc_i + ADDR_W'(2)
                   + ({{(ADDR_W-IMM_W){bus.id_imm_i[IMM_W-1]}}, bus.id_imm_i} << 1);
        end
    end

    // PC update and the run/drain/halt sequencing.
    // A taken branch wins over stall. HLT freezes the PC and starts the drain.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only; reset is async active-low.
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            drain_q <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (taken) begin
                        pc_q <= target;
                    end else if (is_hlt) begin
                        drain_q <= DW'(DRAIN_CYCLES - 1);
                        state_q <= DRAIN;
                    end else if (!bus.stall_i) begin
                        pc_q <= pc_q + ADDR_W'(2);
                    end
                end
                DRAIN: begin
                    if (!bus.stall_i) begin
                        if (drain_q == '0) begin
                            state_q <= HALTED;
                        end else begin
                            drain_q <= drain_q - DW'(1);
                        end
                    end
                end
                HALTED: begin
                    state_q <= HALTED;
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    // Saturating statistics for resolved and taken B/BR. Stall does not affect counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
        end else begin
            if (act && is_bbr && (br_cnt_q != '1)) begin
                br_cnt_q <= br_cnt_q + CNT_W'(1);
            end
            if (taken && (taken_cnt_q != '1)) begin
                taken_cnt_q <= taken_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.pc_o          = pc_q;
    assign bus.fetch_en_o    = (state_q == RUN);
    assign bus.halted_o      = (state_q == HALTED);
    assign bus.flush_o       = taken | is_hlt;
    assign bus.link_o        = bus.id_pc_i + ADDR_W'(2);
    assign bus.br_count_o    = br_cnt_q;
    assign bus.taken_count_o = taken_cnt_q;
endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit.
// The main instance uses default widths. A second instance with CNT_W=2 exercises counter saturation.
module tb_pc_unit;
    logic clk;
    logic rst_n;
    logic rst_n_s;
    int   n_checks;
    int   n_errors;

    pc_unit_if #(.ADDR_W(16), .IMM_W(9), .CNT_W(16)) bus ();
    pc_unit_if #(.ADDR_W(16), .IMM_W(9), .CNT_W(2))  bus_s ();

    pc_unit #(.ADDR_W(16), .IMM_W(9), .RESET_PC(16'h0000), .DRAIN_CYCLES(3), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    pc_unit #(.ADDR_W(16), .IMM_W(9), .RESET_PC(16'h0000), .DRAIN_CYCLES(3), .CNT_W(2)) dut_s (
        .clk   (clk),
        .rst_n (rst_n_s),
        .bus   (bus_s.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.stall_i      = 1'b0;
        bus.id_valid_i   = 1'b0;
        bus.id_branch_i  = 1'b0;
        bus.id_br_type_i = 2'd0;
        bus.id_cond_i    = 3'd0;
        bus.id_imm_i     = '0;
        bus.id_pc_i      = '0;
        bus.reg_val_i    = '0;
        bus.flags_i      = 3'd0;
    endtask

    task automatic set_br(input logic [1:0] t, input logic [2:0] c, input logic [8:0] imm,
                          input logic [15:0] pc, input logic [15:0] rv, input logic [2:0] fl);
        bus.id_valid_i   = 1'b1;
        bus.id_branch_i  = 1'b1;
        bus.id_br_type_i = t;
        bus.id_cond_i    = c;
        bus.id_imm_i     = imm;
        bus.id_pc_i      = pc;
        bus.reg_val_i    = rv;
        bus.flags_i      = fl;
    endtask

    // Reference condition table, written from the condition definitions.
    function automatic logic exp_taken(input int c, input logic n, input logic v, input logic z);
        case (c)
            0:       return !z;
            1:       return z;
            2:       return !z && !n;
            3:       return n;
            4:       return z || !n;
            5:       return n || z;
            6:       return v;
            default: return 1'b1;
        endcase
    endfunction

    initial begin
        logic [15:0] exp_pc;
        int          br_exp;
        int          tk_exp;
        logic        e;
        logic [2:0]  fl;

        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        rst_n_s  = 1'b0;
        idle();
        bus_s.stall_i      = 1'b0;
        bus_s.id_valid_i   = 1'b0;
        bus_s.id_branch_i  = 1'b0;
        bus_s.id_br_type_i = 2'd0;
        bus_s.id_cond_i    = 3'd7;
        bus_s.id_imm_i     = '0;
        bus_s.id_pc_i      = '0;
        bus_s.reg_val_i    = '0;
        bus_s.flags_i      = 3'd0;

        // Check the reset state.
        #2;
        check("rst_pc", 32'(bus.pc_o), 32'h0);
        check("rst_fetch_en", 32'(bus.fetch_en_o), 1);
        check("rst_flush", 32'(bus.flush_o), 0);
        check("rst_halted", 32'(bus.halted_o), 0);
        check("rst_br_cnt", 32'(bus.br_count_o), 0);
        check("rst_tk_cnt", 32'(bus.taken_count_o), 0);
        rst_n = 1'b1;

        // Sequential fetch, then one stall cycle.
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("seq_pc", 32'(bus.pc_o), 32'(i * 2));
        end
        bus.stall_i = 1'b1;
        tick();
        check("stall_hold", 32'(bus.pc_o), 32'h8);
        bus.stall_i = 1'b0;
        tick();
        check("stall_release", 32'(bus.pc_o), 32'hA);

        // B EQ taken with a negative offset, then the same branch not taken.
        set_br(2'd0, 3'd1, 9'h1FE, 16'h0010, 16'h0, 3'b001);
        #1;
        check("b_eq_flush", 32'(bus.flush_o), 1);
        tick();
        check("b_eq_pc", 32'(bus.pc_o), 32'h000E);
        bus.flags_i = 3'b000;
        #1;
        check("b_ne_flush", 32'(bus.flush_o), 0);
        tick();
        check("b_ne_pc", 32'(bus.pc_o), 32'h0010);
        idle();
        check("cnt_br_2", 32'(bus.br_count_o), 2);
        check("cnt_tk_1", 32'(bus.taken_count_o), 1);

        // BR unconditional under stall: the redirect still wins.
        set_br(2'd1, 3'd7, 9'h0, 16'h0020, 16'hBEEF, 3'b000);
        bus.stall_i = 1'b1;
        #1;
        check("br_flush", 32'(bus.flush_o), 1);
        tick();
        check("br_pc", 32'(bus.pc_o), 32'hBEEF);
        bus.stall_i = 1'b0;

        // PCS: link wraps, no flush, sequential PC, no statistics.
        set_br(2'd2, 3'd7, 9'h0, 16'hFFFE, 16'h0, 3'b000);
        #1;
        check("pcs_link", 32'(bus.link_o), 32'h0000);
        check("pcs_flush", 32'(bus.flush_o), 0);
        tick();
        check("pcs_pc", 32'(bus.pc_o), 32'hBEF1);

        // Sweep every condition against every flag combination.
        exp_pc = 16'hBEF1;
        br_exp = 3;
        tk_exp = 2;
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 8; f++) begin
                fl = 3'(f);
                e  = exp_taken(c, fl[2], fl[1], fl[0]);
                set_br(2'd0, 3'(c), 9'h004, 16'h0100, 16'h0, fl);
                #1;
                check("sweep_flush", 32'(bus.flush_o), 32'(e));
                tick();
                exp_pc = e ? 16'h010A : exp_pc + 16'h2;
                br_exp++;
                if (e) tk_exp++;
                check("sweep_pc", 32'(bus.pc_o), 32'(exp_pc));
            end
        end
        idle();
        check("sweep_br_cnt", 32'(bus.br_count_o), 32'(br_exp));
        check("sweep_tk_cnt", 32'(bus.taken_count_o), 32'(tk_exp));

        // Move to 0x0040, then HLT with one stall during the drain.
        set_br(2'd1, 3'd7, 9'h0, 16'h0030, 16'h0040, 3'b000);
        tick();
        br_exp++;
        tk_exp++;
        check("pre_hlt_pc", 32'(bus.pc_o), 32'h0040);
        set_br(2'd3, 3'd0, 9'h0, 16'h0040, 16'h0, 3'b000);
        #1;
        check("hlt_flush", 32'(bus.flush_o), 1);
        tick();
        check("hlt_pc", 32'(bus.pc_o), 32'h0040);
        check("drain_fetch_en", 32'(bus.fetch_en_o), 0);
        // During the drain, present a taken BR. It must be ignored.
        set_br(2'd1, 3'd7, 9'h0, 16'h0040, 16'h1234, 3'b000);
        #1;
        check("drain_flush", 32'(bus.flush_o), 0);
        tick();
        check("drain_halted_1", 32'(bus.halted_o), 0);
        bus.stall_i = 1'b1;
        tick();
        check("drain_halted_2", 32'(bus.halted_o), 0);
        bus.stall_i = 1'b0;
        tick();
        check("drain_halted_3", 32'(bus.halted_o), 0);
        tick();
        check("halted_rise", 32'(bus.halted_o), 1);
        check("halted_pc", 32'(bus.pc_o), 32'h0040);
        #1;
        check("halted_flush", 32'(bus.flush_o), 0);
        tick();
        check("halted_sticky", 32'(bus.halted_o), 1);
        check("halted_pc_2", 32'(bus.pc_o), 32'h0040);
        check("halted_br_cnt", 32'(bus.br_count_o), 32'(br_exp));
        check("halted_tk_cnt", 32'(bus.taken_count_o), 32'(tk_exp));

        // Assert reset asynchronously in HALTED, away from a clock edge.
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_pc", 32'(bus.pc_o), 32'h0);
        check("arst_halted", 32'(bus.halted_o), 0);
        check("arst_fetch_en", 32'(bus.fetch_en_o), 1);
        check("arst_br_cnt", 32'(bus.br_count_o), 0);
        #1;
        rst_n = 1'b1;
        tick();
        check("arst_resume_pc", 32'(bus.pc_o), 32'h2);

        // Saturation on the narrow-counter instance.
        rst_n_s = 1'b1;
        check("sat_rst", 32'(bus_s.taken_count_o), 0);
        bus_s.id_valid_i  = 1'b1;
        bus_s.id_branch_i = 1'b1;
        tick();
        tick();
        check("sat_br_2", 32'(bus_s.br_count_o), 2);
        tick();
        tick();
        tick();
        check("sat_br_5", 32'(bus_s.br_count_o), 3);
        check("sat_tk_5", 32'(bus_s.taken_count_o), 3);
        bus_s.id_valid_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Registered program-counter unit for the pipelined 16-bit core.
- Owns the fetch PC and resolves decode-stage branches (B, BR, PCS, HLT) against the {N,V,Z} flags.
- Generates redirect/flush to IF/ID, runs a halt-drain state machine, and keeps saturating branch statistics.
- Generalises the combinational PC-next logic to parametrised width and adds stall, flush and halt sequencing.

Parameters:
ADDR_W, 16, PC/address width (>= IMM_W+2)
IMM_W, 9, branch immediate width (word offset, sign-extended)
RESET_PC, 0, PC value loaded on reset
DRAIN_CYCLES, 3, cycles after HLT before halted_o asserts (>=1)
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall_i  in  1  hold PC (hazard/memory stall)
id_valid_i  in  1  ID-stage instruction valid
id_branch_i  in  1  ID instruction is branch-class (opcode top bits 11)
id_br_type_i  in  2  0=B, 1=BR, 2=PCS, 3=HLT
id_cond_i  in  3  condition code
id_imm_i  in  IMM_W  branch immediate
id_pc_i  in  ADDR_W  PC of ID instruction
reg_val_i  in  ADDR_W  register operand for BR
flags_i  in  3  {N,V,Z}
pc_o  out  ADDR_W  current fetch PC (pc_q)
fetch_en_o  out  1  1 while in RUN
flush_o  out  1  kill IF/ID instruction this cycle (combinational)
link_o  out  ADDR_W  id_pc_i+2 (PCS result)
halted_o  out  1  core halted (sticky)
br_count_o  out  CNT_W  resolved B/BR count, saturating
taken_count_o  out  CNT_W  taken B/BR count, saturating

Behaviour:
- Reset (async, rst_n=0): pc_q=RESET_PC, state=RUN, drain counter=0, both stat counters=0. Outputs follow: fetch_en_o=1, flush_o=0, halted_o=0. Reset mid-drain or in HALTED returns to RUN immediately.
- act = id_valid_i & id_branch_i & (state==RUN).
- Conditions (flags N=flags_i[2], V=flags_i[1], Z=flags_i[0]):
  - 0 NEQ Z=0; 1 EQ Z=1; 2 GT Z=0&N=0; 3 LT N=1
  - 4 GTE Z=1|(Z=0&N=0); 5 LTE N=1|Z=1; 6 OVF V=1; 7 unconditional
- Targets:
  - type 0: id_pc_i + 2 + (sign-extended id_imm_i << 1), modulo 2^ADDR_W, overflow ignored.
  - type 1: reg_val_i.
- taken = act & type in {0,1} & cond true.
- States:
  - RUN:
    - taken -> pc_q<=target, flush_o=1. Redirect wins over stall_i.
    - act & type 3 -> pc_q holds, flush_o=1, drain counter<=DRAIN_CYCLES-1, go DRAIN.
    - else stall_i -> hold.
    - else pc_q<=pc_q+2 (wraps).
    - PCS (type 2) and not-taken B/BR -> sequential, flush_o=0.
  - DRAIN:
    - pc_q holds, fetch_en_o=0, flush_o=0.
    - ID inputs ignored.
    - Counter decrements on cycles with stall_i=0; at 0 with stall_i=0 -> HALTED.
  - HALTED: halted_o=1, pc_q holds, sticky until reset.
- Timing:
  - flush_o is combinational in the same cycle as act.
  - pc_o updates at the next edge.
  - link_o is combinational: id_pc_i+2, wraps.
- Statistics (same edge):
  - br_count_o += 1 when act & type in {0,1}.
  - taken_count_o += 1 on taken.
  - Both saturate at all-ones, no wrap.
  - Not gated by stall_i.

Test Plan:
- Reset RESET_PC=0, no branches, 4 cycles -> pc_o 0,2,4,6,8; stall_i=1 one cycle -> pc_o held once.
- B cond=1 (EQ), Z=1, id_pc=0x0010, imm=0x1FE (-2) -> flush_o=1, next pc_o=0x000E. Same with Z=0 -> sequential, flush_o=0. br_count=2, taken_count=1.
- BR cond=7, reg_val=0xBEEF with stall_i=1 -> pc_o=0xBEEF next cycle (redirect beats stall). PCS id_pc=0xFFFE -> link_o=0x0000.
- Cond sweep 0-7 over all 8 flag combos -> taken matches table (e.g. GTE with N=1,Z=0 -> not taken).
- HLT at pc 0x0040, DRAIN_CYCLES=3, one stall during drain -> halted_o rises exactly 4 cycles after HLT. pc_o frozen, later branches ignored. rst_n low mid-HALTED -> pc_o=RESET_PC, halted_o=0 asynchronously.
- CNT_W=2, 5 taken branches -> counters stick at 3.
